spi_req_arbiter: RTL and testbench
==================================

# spi_req_arbiter

Two-port request arbiter that shares one `spi_master_controller` between two independent requesters. It accepts 32-bit request words, grants the controller to one requester at a time, and holds that grant from issue until the controller's end-of-transmit. It routes read data back to the owning requester and rejects malformed commands locally so the controller can never be left hung. It sits directly in front of the controller's tx/rx streams and `eot_o`.

## Interface
Parameters:
- `WDT_CYCLES`, default 16'd65535: end-of-transmit watchdog limit in clk cycles; 0 disables the watchdog.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i` in 1: system clock.
  - `rst_n_i` in 1: asynchronous active-low reset.
- Requester side:
  - `req_data_i[k]` in 2x32: request word, k = 0..1; `{cmd[31:28], addr[27:24], len[23:16], wdata[15:0]}`.
  - `req_vld_i[k]` in 2x1: request valid.
  - `req_rdy_o[k]` out 2x1: request accepted.
  - `resp_data_o` out 32: read data, shared by both requesters.
  - `resp_vld_o[k]` out 2x1: read data valid for requester k.
  - `resp_rdy_i[k]` in 2x1: requester k ready for read data.
  - `req_err_o[k]` out 2x1: one-cycle pulse; requester k's command was rejected.
- Controller side:
  - `m_tx_data_o` out 32: request word to the controller.
  - `m_tx_vld_o` out 1: request valid to the controller.
  - `m_tx_rdy_i` in 1: controller ready.
  - `m_rx_data_i` in 32: read data from the controller.
  - `m_rx_vld_i` in 1: read data valid from the controller.
  - `m_rx_rdy_o` out 1: ready toward the controller's read data.
  - `m_eot_i` in 1: end-of-transmit pulse from the controller.
- Status:
  - `busy_o` out 1: high whenever state ≠ IDLE.
  - `owner_o` out 1: index of the current grant holder.
  - `wdt_o` out 1: one-cycle pulse on watchdog expiry.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive the request to the controller.
  - WAIT_EOT: transaction in flight.
  - DRAIN: flush pending read data after eot.
- IDLE:
  - Winner among asserted `req_vld_i` gets `req_rdy_o` high combinationally that cycle.
  - Winner's word is captured into an internal request register and `owner` is set to the winner.
  - If the captured cmd is 4'hA (read) or 4'hB (write): go to ISSUE.
  - Otherwise: stay in IDLE and pulse `req_err_o[owner]` next cycle; nothing is sent to the controller.
- ISSUE:
  - `m_tx_vld_o` = 1 and `m_tx_data_o` = captured word.
  - On `m_tx_vld_o & m_tx_rdy_i`: go to WAIT_EOT.
- WAIT_EOT:
  - `resp_data_o` = `m_rx_data_i`.
  - `resp_vld_o[owner]` = `m_rx_vld_i`; `m_rx_rdy_o` = `resp_rdy_i[owner]`.
  - On `m_eot_i`: go to DRAIN if `m_rx_vld_i & ~m_rx_rdy_o`, else IDLE.
- DRAIN:
  - Same read-data routing as WAIT_EOT.
  - Go to IDLE once `m_rx_vld_i` is low.
- Outside WAIT_EOT and DRAIN:
  - `m_rx_rdy_o` = 1, so stray read data is discarded.
  - `resp_vld_o` = 0.
- Writes: any read data that appears is still routed to the owner.
- Watchdog:
  - 16-bit counter cleared on entry to WAIT_EOT; increments each WAIT_EOT cycle.
  - When it reaches `WDT_CYCLES` (nonzero), the block pulses `wdt_o` and goes to IDLE.
  - The grant is released; there is no retry.
- `m_eot_i` outside WAIT_EOT is ignored.

## Timing
- Reset values:
  - State IDLE, owner 0, priority pointer 0.
  - All `*_vld_o`, `req_rdy_o`, `req_err_o` and `wdt_o` = 0.
  - `m_tx_data_o` = 0, `resp_data_o` = 0, `busy_o` = 0.
  - `m_rx_rdy_o` = 1.
- Reset mid-transaction: immediate return to IDLE. No outputs are held.
- Latency:
  - `req_vld_i` high in IDLE at cycle N gives `req_rdy_o` at N and `m_tx_vld_o` at N+1.
  - `m_eot_i` at cycle M (nothing pending) gives IDLE at M+1; the next grant is possible at M+1.
- `req_err_o` is a pulse at N+1. The block is back in IDLE at N+1 and can grant again then.
- Read-data path is combinational pass-through; it adds no cycles.
- `m_tx_vld_o` is held with stable data until accepted. It never drops while `m_tx_rdy_i` is low.
- `m_eot_i` and the final `m_rx_vld_i` in the same cycle: that beat is still routed to the owner, and DRAIN is entered only if it is not consumed.
- The priority pointer updates only on a grant, including rejected grants.

## Configuration
- `SPI_ARB_RR_EN` defined:
  - Round-robin arbitration; on contention, the requester not granted last wins.
  - Pointer after reset favours requester 0.
- `SPI_ARB_RR_EN` undefined:
  - Fixed priority; requester 0 always wins on contention.
  - Priority pointer logic is absent.

## Test plan
- Single read: req0 = 32'hA3_08_0000; controller returns rx word 32'h0000_00C5 then `m_eot_i` → `m_tx_data_o` = 32'hA308_0000 at cycle N+1; `resp_vld_o[0]` with 32'h0000_00C5; `resp_vld_o[1]` never high; IDLE one cycle after eot.
- Contention:
  - Both requesters hold writes 32'hB1_10_ABCD and 32'hB2_10_1234 continuously.
  - RR build: grants alternate 0,1,0,1.
  - Fixed-priority build: req0 is granted every time.
- Invalid command: req1 = 32'h5000_0000 → `req_rdy_o[1]` at N, `req_err_o[1]` at N+1, `m_tx_vld_o` stays 0.
- Backpressure:
  - Hold `m_tx_rdy_i` = 0 for 10 cycles → `m_tx_vld_o` and the data stay stable.
  - `resp_rdy_i[0]` = 0 across `m_eot_i` → DRAIN entered; leaves DRAIN when the word is consumed.
- Watchdog: `WDT_CYCLES` = 20, no eot → `wdt_o` pulse 20 cycles after WAIT_EOT entry; IDLE and `busy_o` = 0 next cycle.
- Reset mid-WAIT_EOT: assert `rst_n_i` low → all outputs at reset values immediately; a new request after release is granted normally.

Source files
------------

// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: requester, controller and status signals of the
// two-port SPI request arbiter. The slave modport is the arbiter's view.
// The master modport is the view of the surrounding environment.
interface spi_req_arbiter_if;
    logic [1:0][31:0] req_data_i;
    logic [1:0]       req_vld_i;
    logic [1:0]       req_rdy_o;
    logic [31:0]      resp_data_o;
    logic [1:0]       resp_vld_o;
    logic [1:0]       resp_rdy_i;
    logic [1:0]       req_err_o;
    logic [31:0]      m_tx_data_o;
    logic             m_tx_vld_o;
    logic             m_tx_rdy_i;
    logic [31:0]      m_rx_data_i;
    logic             m_rx_vld_i;
    logic             m_rx_rdy_o;
    logic             m_eot_i;
    logic             busy_o;
    logic             owner_o;
    logic             wdt_o;

    modport slave (
        input  req_data_i, req_vld_i, resp_rdy_i,
        input  m_tx_rdy_i, m_rx_data_i, m_rx_vld_i, m_eot_i,
        output req_rdy_o, resp_data_o, resp_vld_o, req_err_o,
        output m_tx_data_o, m_tx_vld_o, m_rx_rdy_o,
        output busy_o, owner_o, wdt_o
    );

    modport master (
        output req_data_i, req_vld_i, resp_rdy_i,
        output m_tx_rdy_i, m_rx_data_i, m_rx_vld_i, m_eot_i,
        input  req_rdy_o, resp_data_o, resp_vld_o, req_err_o,
        input  m_tx_data_o, m_tx_vld_o, m_rx_rdy_o,
        input  busy_o, owner_o, wdt_o
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one SPI master controller between two requesters.
// The grant is held from issue until end-of-transmit. Read data is routed
// to the owner. Bad commands are rejected locally.
// The eot watchdog is WDT_CYCLES cycles; a value of 0 disables it.
// Build option: define SPI_ARB_RR_EN for round-robin arbitration.
// The default build uses fixed priority, with requester 0 winning.
module spi_req_arbiter #(
    parameter logic [15:0] WDT_CYCLES = 16'd65535
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    spi_req_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] req_q, req_d;
    logic        owner_q, owner_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        winner;
    logic        any_req;
    logic        rx_route;
    logic        wdt_hit;
    logic [3:0]  win_cmd;
`ifdef SPI_ARB_RR_EN
    logic        ptr_q, ptr_d;
`endif

    // Arbitration: pick a winner among the asserted requests
    always_comb begin
        any_req = |bus.req_vld_i;
`ifdef SPI_ARB_RR_EN
        winner  = (&bus.req_vld_i) ? ptr_q : bus.req_vld_i[1];
`else
        winner  = ~bus.req_vld_i[0];
`endif
        win_cmd = bus.req_data_i[winner][31:28];
    end

    // Output decode: tx drive, read-data routing and status
    always_comb begin
        rx_route         = (state_q == S_WAIT) || (state_q == S_DRAIN);
        wdt_hit          = (state_q == S_WAIT) && (WDT_CYCLES != 16'd0) &&
                           (cnt_q == WDT_CYCLES) && !bus.m_eot_i;
        bus.req_rdy_o    = 2'b00;
        if (state_q == S_IDLE && any_req)
            bus.req_rdy_o = winner ? 2'b10 : 2'b01;
        bus.m_tx_vld_o   = (state_q == S_ISSUE);
        bus.m_tx_data_o  = req_q;
        bus.m_rx_rdy_o   = rx_route ? bus.resp_rdy_i[owner_q] : 1'b1;
        bus.resp_vld_o   = 2'b00;
        if (rx_route && bus.m_rx_vld_i)
            bus.resp_vld_o = owner_q ? 2'b10 : 2'b01;
        bus.resp_data_o  = rx_route ? bus.m_rx_data_i : 32'd0;
        bus.req_err_o    = err_q;
        bus.busy_o       = (state_q != S_IDLE);
        bus.owner_o      = owner_q;
        bus.wdt_o        = wdt_hit;
    end

    // Next-state logic for state, captured request, owner, error and watchdog
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        err_d   = 2'b00;
        cnt_d   = cnt_q;
`ifdef SPI_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_d   = bus.req_data_i[winner];
                    owner_d = winner;
`ifdef SPI_ARB_RR_EN
                    ptr_d   = ~winner;
`endif
                    if (win_cmd == 4'hA || win_cmd == 4'hB)
                        state_d = S_ISSUE;
                    else
                        err_d = winner ? 2'b10 : 2'b01;
                end
            end
            S_ISSUE: begin
                if (bus.m_tx_rdy_i) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'd0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.m_eot_i)
                    state_d = (bus.m_rx_vld_i && !bus.m_rx_rdy_o) ? S_DRAIN : S_IDLE;
                else if (wdt_hit)
                    state_d = S_IDLE;
            end
            default: begin
                if (!bus.m_rx_vld_i)
                    state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset returns to IDLE immediately
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            req_q   <= 32'd0;
            owner_q <= 1'b0;
            err_q   <= 2'b00;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SPI_ARB_RR_EN
    // Round-robin pointer: favours the requester not granted last
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end
`endif
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed scenarios and randomized transactions.
// Each outcome is checked against expectations derived from the arbiter's rules.
module tb_spi_req_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   fav = 1'b0;  // requester favoured on contention (round-robin build)

    spi_req_arbiter_if bus();

    spi_req_arbiter #(.WDT_CYCLES(16'd20)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_data_i  = '0;
        bus.req_vld_i   = 2'b00;
        bus.resp_rdy_i  = 2'b11;
        bus.m_tx_rdy_i  = 1'b0;
        bus.m_rx_data_i = 32'd0;
        bus.m_rx_vld_i  = 1'b0;
        bus.m_eot_i     = 1'b0;
    endtask

    // Expected winner for a request mask under the build's arbitration rule
    function automatic bit exp_win(input logic [1:0] m);
        if (m == 2'b01) return 1'b0;
        if (m == 2'b10) return 1'b1;
`ifdef SPI_ARB_RR_EN
        return fav;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] oh(input bit k);
        return k ? 2'b10 : 2'b01;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
        checks++; if (bus.m_tx_vld_o !== 1'b0) begin errors++; $display("FAIL reset_txvld got=%b want=0", bus.m_tx_vld_o); end
        checks++; if (bus.m_tx_data_o !== 32'd0) begin errors++; $display("FAIL reset_txdata got=%h want=0", bus.m_tx_data_o); end
        checks++; if (bus.m_rx_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rxrdy got=%b want=1", bus.m_rx_rdy_o); end
        checks++; if ({bus.req_rdy_o, bus.req_err_o, bus.resp_vld_o, bus.wdt_o, bus.owner_o} !== 8'd0) begin
            errors++; $display("FAIL reset_ctl got=%b want=0", {bus.req_rdy_o, bus.req_err_o, bus.resp_vld_o, bus.wdt_o, bus.owner_o}); end
        checks++; if (bus.resp_data_o !== 32'd0) begin errors++; $display("FAIL reset_respdata got=%h want=0", bus.resp_data_o); end
        rst_n = 1'b1;
        fav = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        bus.req_vld_i = 2'b01; bus.req_data_i[0] = 32'hA308_0000;
        #2;
        checks++; if (bus.req_rdy_o !== 2'b01) begin errors++; $display("FAIL read_rdy got=%b want=01", bus.req_rdy_o); end
        checks++; if (bus.m_tx_vld_o !== 1'b0) begin errors++; $display("FAIL read_txvld_n got=%b want=0", bus.m_tx_vld_o); end
        fav = 1'b1;
        tick();
        bus.req_vld_i = 2'b00; bus.m_tx_rdy_i = 1'b1;
        #2;
        checks++; if (bus.m_tx_vld_o !== 1'b1 || bus.m_tx_data_o !== 32'hA308_0000) begin
            errors++; $display("FAIL read_tx got=%b/%h want=1/a3080000", bus.m_tx_vld_o, bus.m_tx_data_o); end
        tick();
        bus.m_tx_rdy_i = 1'b0; bus.m_rx_vld_i = 1'b1; bus.m_rx_data_i = 32'h0000_00C5; bus.resp_rdy_i = 2'b01;
        #2;
        checks++; if (bus.resp_vld_o !== 2'b01 || bus.resp_data_o !== 32'h0000_00C5) begin
            errors++; $display("FAIL read_resp got=%b/%h want=01/000000c5", bus.resp_vld_o, bus.resp_data_o); end
        checks++; if (bus.m_rx_rdy_o !== 1'b1) begin errors++; $display("FAIL read_rxrdy got=%b want=1", bus.m_rx_rdy_o); end
        tick();
        bus.m_rx_vld_i = 1'b0; bus.m_eot_i = 1'b1;
        #2;
        checks++; if (bus.busy_o !== 1'b1 || bus.resp_vld_o !== 2'b00) begin
            errors++; $display("FAIL read_eot got=%b/%b want=1/00", bus.busy_o, bus.resp_vld_o); end
        tick();
        bus.m_eot_i = 1'b0; bus.resp_rdy_i = 2'b11;
        #2;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL read_idle got=%b want=0", bus.busy_o); end
    endtask

    task automatic test_invalid();
        tick();
        bus.req_vld_i = 2'b10; bus.req_data_i[1] = 32'h5000_0000;
        #2;
        checks++; if (bus.req_rdy_o !== 2'b10) begin errors++; $display("FAIL inv_rdy got=%b want=10", bus.req_rdy_o); end
        fav = 1'b0;
        tick();
        bus.req_vld_i = 2'b00;
        #2;
        checks++; if (bus.req_err_o !== 2'b10) begin errors++; $display("FAIL inv_err got=%b want=10", bus.req_err_o); end
        checks++; if (bus.m_tx_vld_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL inv_tx got=%b/%b want=0/0", bus.m_tx_vld_o, bus.busy_o); end
        tick();
        #2;
        checks++; if (bus.req_err_o !== 2'b00) begin errors++; $display("FAIL inv_err_clr got=%b want=00", bus.req_err_o); end
    endtask

    task automatic test_backpressure();
        int n;
        tick();
        bus.req_vld_i = 2'b01; bus.req_data_i[0] = 32'hB1_10_ABCD;
        fav = 1'b1;
        tick();
        bus.req_vld_i = 2'b00; bus.m_tx_rdy_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            checks++; if (bus.m_tx_vld_o !== 1'b1 || bus.m_tx_data_o !== 32'hB110_ABCD) begin
                errors++; $display("FAIL bp_tx_hold[%0d] got=%b/%h want=1/b110abcd", i, bus.m_tx_vld_o, bus.m_tx_data_o); end
            tick();
        end
        bus.m_tx_rdy_i = 1'b1;
        tick();
        bus.m_tx_rdy_i = 1'b0; bus.m_rx_vld_i = 1'b1; bus.m_rx_data_i = 32'h1234_5678;
        bus.resp_rdy_i = 2'b10; bus.m_eot_i = 1'b1;
        #2;
        checks++; if (bus.m_rx_rdy_o !== 1'b0 || bus.resp_vld_o !== 2'b01) begin
            errors++; $display("FAIL bp_eot got=%b/%b want=0/01", bus.m_rx_rdy_o, bus.resp_vld_o); end
        tick();
        bus.m_eot_i = 1'b0;
        #2;
        checks++; if (bus.busy_o !== 1'b1 || bus.resp_vld_o !== 2'b01 || bus.resp_data_o !== 32'h1234_5678) begin
            errors++; $display("FAIL bp_drain got=%b/%b/%h want=1/01/12345678", bus.busy_o, bus.resp_vld_o, bus.resp_data_o); end
        bus.resp_rdy_i = 2'b01;
        #1;
        checks++; if (bus.m_rx_rdy_o !== 1'b1) begin errors++; $display("FAIL bp_drain_rdy got=%b want=1", bus.m_rx_rdy_o); end
        tick();
        bus.m_rx_vld_i = 1'b0; bus.resp_rdy_i = 2'b11;
        n = 0;
        #2;
        while (bus.busy_o !== 1'b0 && n < 3) begin tick(); #2; n++; end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL bp_leave_drain got=%b want=0", bus.busy_o); end
    endtask

    task automatic test_contention();
        logic [1:0][31:0] w;
        bit g;
        w[0] = 32'hB1_10_ABCD; w[1] = 32'hB2_10_1234;
        tick();
        bus.req_data_i = w; bus.req_vld_i = 2'b11; bus.m_tx_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            g = exp_win(2'b11);
            checks++; if (bus.req_rdy_o !== oh(g)) begin
                errors++; $display("FAIL cont_grant[%0d] got=%b want=%b", i, bus.req_rdy_o, oh(g)); end
            fav = ~g;
            tick();
            #2;
            checks++; if (bus.m_tx_vld_o !== 1'b1 || bus.m_tx_data_o !== w[g] || bus.owner_o !== g) begin
                errors++; $display("FAIL cont_tx[%0d] got=%b/%h/%b want=1/%h/%b", i, bus.m_tx_vld_o, bus.m_tx_data_o, bus.owner_o, w[g], g); end
            tick();
            bus.m_eot_i = 1'b1;
            tick();
            bus.m_eot_i = 1'b0;
        end
        bus.req_vld_i = 2'b00; bus.m_tx_rdy_i = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int k;
        bus.req_vld_i = 2'b10; bus.req_data_i[1] = 32'hA2_04_0000;
        fav = 1'b0;
        tick();
        bus.req_vld_i = 2'b00; bus.m_tx_rdy_i = 1'b1;
        tick();
        bus.m_tx_rdy_i = 1'b0;
        k = 0;
        #2;
        while (bus.wdt_o !== 1'b1 && k < 40) begin tick(); #2; k++; end
        checks++; if (k != 20) begin errors++; $display("FAIL wdt_delay got=%0d want=20", k); end
        tick();
        #2;
        checks++; if (bus.busy_o !== 1'b0 || bus.wdt_o !== 1'b0) begin
            errors++; $display("FAIL wdt_idle got=%b/%b want=0/0", bus.busy_o, bus.wdt_o); end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.req_vld_i = 2'b01; bus.req_data_i[0] = 32'hA1_02_0000;
        tick();
        bus.req_vld_i = 2'b00; bus.m_tx_rdy_i = 1'b1;
        tick();
        bus.m_tx_rdy_i = 1'b0; bus.m_rx_vld_i = 1'b1; bus.m_rx_data_i = 32'hDEAD_BEEF; bus.resp_rdy_i = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy_o, bus.m_tx_vld_o, bus.resp_vld_o, bus.owner_o, bus.req_err_o, bus.wdt_o} !== 8'd0) begin
            errors++; $display("FAIL rstmid_ctl got=%b want=0", {bus.busy_o, bus.m_tx_vld_o, bus.resp_vld_o, bus.owner_o, bus.req_err_o, bus.wdt_o}); end
        checks++; if (bus.m_rx_rdy_o !== 1'b1 || bus.resp_data_o !== 32'd0 || bus.m_tx_data_o !== 32'd0) begin
            errors++; $display("FAIL rstmid_data got=%b/%h/%h want=1/0/0", bus.m_rx_rdy_o, bus.resp_data_o, bus.m_tx_data_o); end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        fav = 1'b0;
        tick();
        bus.req_vld_i = 2'b10; bus.req_data_i[1] = 32'hB3_01_5555;
        #2;
        checks++; if (bus.req_rdy_o !== 2'b10) begin errors++; $display("FAIL rstmid_grant got=%b want=10", bus.req_rdy_o); end
        fav = 1'b0;
        tick();
        bus.req_vld_i = 2'b00; bus.m_tx_rdy_i = 1'b1;
        #2;
        checks++; if (bus.m_tx_vld_o !== 1'b1 || bus.m_tx_data_o !== 32'hB301_5555) begin
            errors++; $display("FAIL rstmid_tx got=%b/%h want=1/b3015555", bus.m_tx_vld_o, bus.m_tx_data_o); end
        tick();
        bus.m_tx_rdy_i = 1'b0; bus.m_eot_i = 1'b1;
        tick();
        bus.m_eot_i = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [1:0][31:0] w;
        logic [1:0] mask;
        logic [3:0] cmd;
        logic [31:0] rd;
        int sel, stall, beats, tries;
        bit g, consumed;
        for (int t = 0; t < 40; t++) begin
            mask = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                sel = $urandom_range(0, 4);
                if (sel == 0 || sel == 2) cmd = 4'hA;
                else if (sel == 1)        cmd = 4'hB;
                else begin
                    sel = $urandom_range(0, 13);
                    cmd = (sel >= 10) ? 4'(sel + 2) : 4'(sel);
                end
                w[k] = {cmd, 28'($urandom)};
            end
            bus.req_data_i = w; bus.req_vld_i = mask;
            #2;
            g = exp_win(mask);
            checks++; if (bus.req_rdy_o !== oh(g)) begin
                errors++; $display("FAIL rnd_grant[%0d] got=%b want=%b", t, bus.req_rdy_o, oh(g)); end
            fav = ~g;
            cmd = w[g][31:28];
            tick();
            bus.req_vld_i = 2'b00;
            #2;
            checks++; if (bus.owner_o !== g) begin errors++; $display("FAIL rnd_owner[%0d] got=%b want=%b", t, bus.owner_o, g); end
            if (cmd != 4'hA && cmd != 4'hB) begin
                checks++; if (bus.req_err_o !== oh(g) || bus.m_tx_vld_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                    errors++; $display("FAIL rnd_reject[%0d] got=%b/%b/%b want=%b/0/0", t, bus.req_err_o, bus.m_tx_vld_o, bus.busy_o, oh(g)); end
                tick();
                continue;
            end
            stall = $urandom_range(0, 3);
            repeat (stall) begin
                checks++; if (bus.m_tx_vld_o !== 1'b1 || bus.m_tx_data_o !== w[g]) begin
                    errors++; $display("FAIL rnd_stall[%0d] got=%b/%h want=1/%h", t, bus.m_tx_vld_o, bus.m_tx_data_o, w[g]); end
                tick();
                #2;
            end
            bus.m_tx_rdy_i = 1'b1;
            #1;
            checks++; if (bus.m_tx_vld_o !== 1'b1 || bus.m_tx_data_o !== w[g]) begin
                errors++; $display("FAIL rnd_tx[%0d] got=%b/%h want=1/%h", t, bus.m_tx_vld_o, bus.m_tx_data_o, w[g]); end
            tick();
            bus.m_tx_rdy_i = 1'b0;
            beats = (cmd == 4'hA) ? $urandom_range(1, 2) : $urandom_range(0, 1);
            for (int b = 0; b < beats; b++) begin
                rd = $urandom;
                bus.m_rx_data_i = rd; bus.m_rx_vld_i = 1'b1;
                tries = 0;
                consumed = 1'b0;
                while (!consumed) begin
                    bus.resp_rdy_i = (tries >= 3) ? 2'b11 : 2'($urandom_range(0, 3));
                    #2;
                    checks++; if (bus.resp_vld_o !== oh(g) || bus.resp_data_o !== rd || bus.m_rx_rdy_o !== bus.resp_rdy_i[g]) begin
                        errors++; $display("FAIL rnd_resp[%0d] got=%b/%h/%b want=%b/%h/%b", t, bus.resp_vld_o, bus.resp_data_o,
                                           bus.m_rx_rdy_o, oh(g), rd, bus.resp_rdy_i[g]); end
                    consumed = bus.resp_rdy_i[g];
                    tick();
                    tries++;
                end
            end
            bus.m_rx_vld_i = 1'b0; bus.m_eot_i = 1'b1;
            #2;
            checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rnd_busy[%0d] got=%b want=1", t, bus.busy_o); end
            tick();
            bus.m_eot_i = 1'b0; bus.resp_rdy_i = 2'b11;
            #2;
            checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d] got=%b want=0", t, bus.busy_o); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_invalid();
        test_backpressure();
        test_contention();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
